dsp_mac_pipe: RTL and testbench

Parametrised, handshaked multiply-accumulate slice. It is the next-generation arithmetic tile for the DSP datapath. It provides:
- generic operand and accumulator widths,
- a configurable-depth multiplier pipeline,
- a signed or unsigned pre-adder,
- per-beat mode selection,
- saturating or wrapping accumulation with an overflow flag,
- valid/ready flow control so it chains directly between streaming blocks.

---
 rtl/dsp_mac_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: handshaked multiply-accumulate slice.
//
// Datapath: optional pre-adder (A or D+A), full-precision multiply by B,
// then a post-adder that loads M, C+M, P+M or P-M into the output register P.
// The result is range-checked at ACC_WIDTH+2 bits and either clamped or
// wrapped, with OVF flagging that beat.
//
// Ports:
//   CLK        rising-edge clock
//   RSTN       synchronous active-low reset
//   IN_VALID   input beat present
//   IN_READY   slice accepts a beat this cycle
//   A, D       pre-adder operands (A_WIDTH)
//   B          multiplier operand (B_WIDTH)
//   C          post-adder load operand (ACC_WIDTH)
//   MODE       per-beat opcode: [2] pre-add enable, [1:0] post-adder op
//   OUT_VALID  P/OVF hold a result
//   OUT_READY  downstream accepts result
//   P          result / accumulator (ACC_WIDTH)
//   OVF        current result overflowed the accumulator range
//
// Pipeline: input regs (p0) -> PIPE_STAGES multiplier regs -> P/OVF.
// A single global stall (OUT_VALID && !OUT_READY) freezes every stage.
module dsp_mac_pipe #(
    parameter int A_WIDTH     = 18,
    parameter int B_WIDTH     = 18,
    parameter int ACC_WIDTH   = 48,
    parameter int PIPE_STAGES = 2,
    parameter int SIGNED      = 1,
    parameter int SATURATE    = 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [A_WIDTH-1:0]   D,
    input  logic [B_WIDTH-1:0]   B,
    input  logic [ACC_WIDTH-1:0] C,
    input  logic [2:0]           MODE,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ACC_WIDTH-1:0] P,
    output logic                 OVF
);

    localparam int   AD_W = A_WIDTH + 1;
    localparam int   M_W  = AD_W + B_WIDTH;
    localparam int   R_W  = ACC_WIDTH + 2;
    localparam int   LAST = PIPE_STAGES - 1;
    localparam logic SGN  = (SIGNED != 0);

    if (ACC_WIDTH < M_W) begin : g_bad_acc_width
        $error("dsp_mac_pipe: ACC_WIDTH must be >= A_WIDTH+1+B_WIDTH");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
        $error("dsp_mac_pipe: PIPE_STAGES must be in 1..4");
    end

    // Operand extension: sign-extend when SIGNED, zero-extend otherwise.
    function automatic logic [AD_W-1:0] ext_a(input logic [A_WIDTH-1:0] x);
        return {SGN & x[A_WIDTH-1], x};
    endfunction

    function automatic logic [M_W-1:0] widen_ad(input logic [AD_W-1:0] x);
        return {{B_WIDTH{SGN & x[AD_W-1]}}, x};
    endfunction

    function automatic logic [M_W-1:0] widen_b(input logic [B_WIDTH-1:0] x);
        return {{AD_W{SGN & x[B_WIDTH-1]}}, x};
    endfunction

    function automatic logic [R_W-1:0] widen_m(input logic [M_W-1:0] x);
        return {{(R_W-M_W){SGN & x[M_W-1]}}, x};
    endfunction

    function automatic logic [R_W-1:0] widen_acc(input logic [ACC_WIDTH-1:0] x);
        return {{2{SGN & x[ACC_WIDTH-1]}}, x};
    endfunction

    // Returns {ovf, value}. The two guard bits of r decide the range check:
    // signed results must have r[R_W-1:ACC_WIDTH-1] all equal; unsigned
    // results are negative when the top bit is set and too large when bit
    // ACC_WIDTH is set.
    function automatic logic [ACC_WIDTH:0] saturate(input logic [R_W-1:0] r);
        logic                 ovf;
        logic [ACC_WIDTH-1:0] val;
        if (SGN) begin
            ovf = !((r[R_W-1:ACC_WIDTH-1] == '0) || (r[R_W-1:ACC_WIDTH-1] == '1));
            val = r[R_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            ovf = r[R_W-1] | r[ACC_WIDTH];
            val = r[R_W-1] ? '0 : '1;
        end
        if (!ovf || SATURATE == 0) begin
            val = r[ACC_WIDTH-1:0];
        end
        return {ovf, val};
    endfunction

    logic stall;
    logic adv;

    assign stall    = OUT_VALID && !OUT_READY;
    assign adv      = !stall;
    assign IN_READY = RSTN && !stall;

    // ---- stage 0: input capture ----
    logic                 vld_p0;
    logic [A_WIDTH-1:0]   a_p0;
    logic [A_WIDTH-1:0]   d_p0;
    logic [B_WIDTH-1:0]   b_p0;
    logic [ACC_WIDTH-1:0] c_p0;
    logic [2:0]           mode_p0;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= IN_VALID;
        end
    end

    always_ff @(posedge CLK) begin
        if (adv && IN_VALID) begin
            a_p0    <= A;
            d_p0    <= D;
            b_p0    <= B;
            c_p0    <= C;
            mode_p0 <= MODE;
        end
    end

    // ---- stages 1..PIPE_STAGES: pre-add, multiply, delay ----
    // Array index i holds pipeline stage p(i+1).
    logic [AD_W-1:0]        ad_c;
    logic [M_W-1:0]         prod_c;
    logic [PIPE_STAGES-1:0] vld_pm;
    logic [M_W-1:0]         prod_pm [PIPE_STAGES];
    logic [ACC_WIDTH-1:0]   c_pm    [PIPE_STAGES];
    logic [1:0]             op_pm   [PIPE_STAGES];

    always_comb begin
        ad_c = ext_a(a_p0);
        if (mode_p0[2]) begin
            ad_c = ext_a(d_p0) + ext_a(a_p0);
        end
        prod_c = widen_ad(ad_c) * widen_b(b_p0);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            vld_pm <= '0;
        end else if (adv) begin
            vld_pm[0] <= vld_p0;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_pm[i] <= vld_pm[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (adv) begin
            prod_pm[0] <= prod_c;
            c_pm[0]    <= c_p0;
            op_pm[0]   <= mode_p0[1:0];
            for (int i = 1; i < PIPE_STAGES; i++) begin
                prod_pm[i] <= prod_pm[i-1];
                c_pm[i]    <= c_pm[i-1];
                op_pm[i]   <= op_pm[i-1];
            end
        end
    end

    // ---- final stage: post-adder, range check, P/OVF register ----
    logic [R_W-1:0]     r_c;
    logic [ACC_WIDTH:0] sat_c;

    always_comb begin
        case (op_pm[LAST])
            2'b00:   r_c = widen_m(prod_pm[LAST]);
            2'b01:   r_c = widen_acc(c_pm[LAST]) + widen_m(prod_pm[LAST]);
            2'b10:   r_c = widen_acc(P) + widen_m(prod_pm[LAST]);
            default: r_c = widen_acc(P) - widen_m(prod_pm[LAST]);
        endcase
        sat_c = saturate(r_c);
    end

    // Bubbles clear OUT_VALID but leave P intact so a later accumulate
    // continues from the last retired result.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            OUT_VALID <= 1'b0;
            P         <= '0;
            OVF       <= 1'b0;
        end else if (adv) begin
            OUT_VALID <= vld_pm[LAST];
            if (vld_pm[LAST]) begin
                P   <= sat_c[ACC_WIDTH-1:0];
                OVF <= sat_c[ACC_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe with default parameters (saturating)
// plus a wrapping instance driven by the same stimulus.
module tb_dsp_mac_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        out_ready;
    logic [17:0] a;
    logic [17:0] d;
    logic [17:0] b;
    logic [47:0] c;
    logic [2:0]  mode;

    logic        in_ready,  out_valid,  ovf;
    logic [47:0] p;
    logic        in_ready_w, out_valid_w, ovf_w;
    logic [47:0] p_w;

    int total = 0;
    int bad   = 0;
    int sent;
    int next_exp;

    always #5 clk = ~clk;

    dsp_mac_pipe dut (
        .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .D(d), .B(b), .C(c), .MODE(mode),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .P(p), .OVF(ovf)
    );

    dsp_mac_pipe #(.SATURATE(0)) dut_w (
        .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready_w),
        .A(a), .D(d), .B(b), .C(c), .MODE(mode),
        .OUT_VALID(out_valid_w), .OUT_READY(out_ready), .P(p_w), .OVF(ovf_w)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two edges with a beat offered
        rstn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 18'd5; b = 18'd5; d = '0; c = '0; mode = 3'b000;
        cyc();
        chk("rst_in_ready", 48'(in_ready), 48'd0);
        chk("rst_in_ready_w", 48'(in_ready_w), 48'd0);
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_p", p, 48'd0);
        chk("rst_ovf", 48'(ovf), 48'd0);
        cyc();
        chk("rst2_in_ready", 48'(in_ready), 48'd0);
        chk("rst2_out_valid", 48'(out_valid), 48'd0);
        rstn = 1'b1; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 48'(in_ready), 48'd1);
        repeat (6) begin
            cyc();
            chk("rel_no_out", 48'(out_valid), 48'd0);
        end

        // Basic multiply 3 * -4, latency 4
        mode = 3'b000; a = 18'd3; b = 18'h3FFFC; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("mul_lat1", 48'(out_valid), 48'd0);
        cyc();
        chk("mul_lat2", 48'(out_valid), 48'd0);
        cyc();
        chk("mul_lat3", 48'(out_valid), 48'd0);
        cyc();
        chk("mul_valid", 48'(out_valid), 48'd1);
        chk("mul_p", p, 48'hFFFF_FFFF_FFF4);
        chk("mul_ovf", 48'(ovf), 48'd0);
        cyc();
        chk("mul_drain", 48'(out_valid), 48'd0);

        // Pre-add and load: (7+5)*2 + 100
        mode = 3'b101; a = 18'd5; d = 18'd7; b = 18'd2; c = 48'd100; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("preadd_valid", 48'(out_valid), 48'd1);
        chk("preadd_p", p, 48'd124);
        chk("preadd_ovf", 48'(ovf), 48'd0);
        cyc();

        // Back-to-back accumulate, B=10
        d = '0; c = '0; b = 18'd10;
        mode = 3'b000; a = 18'd1; in_valid = 1'b1;
        cyc();
        mode = 3'b010; a = 18'd2;
        cyc();
        a = 18'd3;
        cyc();
        a = 18'd4;
        cyc();
        in_valid = 1'b0;
        chk("acc1_valid", 48'(out_valid), 48'd1);
        chk("acc1_p", p, 48'd10);
        cyc();
        chk("acc2_valid", 48'(out_valid), 48'd1);
        chk("acc2_p", p, 48'd30);
        cyc();
        chk("acc3_valid", 48'(out_valid), 48'd1);
        chk("acc3_p", p, 48'd60);
        cyc();
        chk("acc4_valid", 48'(out_valid), 48'd1);
        chk("acc4_p", p, 48'd100);
        cyc();
        chk("acc_drain", 48'(out_valid), 48'd0);
        chk("acc_p_kept", p, 48'd100);

        // Reset while a beat is in flight: beat is discarded, P restarts at 0
        mode = 3'b000; a = 18'd7; b = 18'd1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        rstn = 1'b0;
        cyc();
        chk("mrst_p", p, 48'd0);
        chk("mrst_out_valid", 48'(out_valid), 48'd0);
        rstn = 1'b1;
        repeat (5) begin
            cyc();
            chk("mrst_no_ghost", 48'(out_valid), 48'd0);
        end
        mode = 3'b010; a = 18'd2; b = 18'd3; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("mrst_acc_valid", 48'(out_valid), 48'd1);
        chk("mrst_acc_p", p, 48'd6);
        cyc();

        // Subtract: 6 - 1*10
        mode = 3'b011; a = 18'd1; b = 18'd10; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("sub_p", p, 48'hFFFF_FFFF_FFFC);
        chk("sub_ovf", 48'(ovf), 48'd0);
        cyc();

        // Backpressure: six beats, OUT_READY low for cycles 4..6
        sent = 0; next_exp = 1;
        for (int k = 0; k < 30; k++) begin
            out_ready = !(k >= 4 && k <= 6);
            in_valid  = (sent < 6);
            mode = 3'b000; a = 18'(sent + 1); b = 18'd1;
            #1;
            if (k >= 4 && k <= 6) begin
                chk("bp_in_ready", 48'(in_ready), 48'd0);
                chk("bp_hold_valid", 48'(out_valid), 48'd1);
            end
            if (out_valid) begin
                chk("bp_seq", p, 48'(next_exp));
                if (out_ready) next_exp++;
            end
            if (in_valid && in_ready) sent++;
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_sent", 48'(sent), 48'd6);
        chk("bp_received", 48'(next_exp), 48'd7);

        // Overflow: (2^47-1) + 1, then a clean beat
        c = 48'h7FFF_FFFF_FFFF; mode = 3'b001; a = 18'd1; b = 18'd1; d = '0; in_valid = 1'b1;
        cyc();
        c = '0; mode = 3'b000;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("sat_valid", 48'(out_valid), 48'd1);
        chk("sat_p", p, 48'h7FFF_FFFF_FFFF);
        chk("sat_ovf", 48'(ovf), 48'd1);
        chk("wrap_valid", 48'(out_valid_w), 48'd1);
        chk("wrap_p", p_w, 48'h8000_0000_0000);
        chk("wrap_ovf", 48'(ovf_w), 48'd1);
        cyc();
        chk("sat_next_p", p, 48'd1);
        chk("sat_next_ovf", 48'(ovf), 48'd0);
        chk("wrap_next_p", p_w, 48'd1);
        chk("wrap_next_ovf", 48'(ovf_w), 48'd0);
        cyc();
        chk("end_drain", 48'(out_valid), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
